chan_sched: RTL and testbench

- Per-frame channel scheduler for the single shared compute resource in the multi-channel codec.
- On each frame sync it sequences channels 0..NCH-1 through the resource: issue start, wait for done, then pulse a shift enable.
- The shift enable advances every per-channel delay line by one position, so each delay line output always holds the state of the channel being processed.
- Sits between the frame timing logic, the compute core and the bank of delay lines.

---
 rtl/sched_pkg.sv | 15 +
 rtl/chan_sched_if.sv | 29 ++
 rtl/sched_wdog.sv | 29 ++
 rtl/chan_sched.sv | 112 +++++++++++
 tb/tb_chan_sched.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sched_pkg.sv
// Shared types and default sizing for the per-frame channel scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam int NCH_DEF = 32;
    localparam int CW_DEF  = 5;
    localparam int TMO_DEF = 255;

endpackage

// File: rtl/chan_sched_if.sv
// Scheduler-facing bundle: frame timing and compute handshake in, sequencing strobes out.
interface chan_sched_if
    import sched_pkg::*;
#(
    parameter int CW = CW_DEF
);

    logic          en;
    logic          fs;
    logic          done;
    logic          start;
    logic [CW-1:0] chan;
    logic          shift_en;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    logic          timeout;

    modport master (
        input  en, fs, done,
        output start, chan, shift_en, busy, frame_done, overrun, timeout
    );

    modport slave (
        output en, fs, done,
        input  start, chan, shift_en, busy, frame_done, overrun, timeout
    );

endinterface

// File: rtl/sched_wdog.sv
// BUSY-state watchdog: counts cycles spent waiting for done and flags when TMO is reached.
module sched_wdog
    import sched_pkg::*;
#(
    parameter int TMO = TMO_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    logic [7:0] cnt;

    // Saturates at TMO so a stalled count cannot wrap back below the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && (cnt != 8'(TMO))) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = run && (cnt == 8'(TMO));

endmodule

// File: rtl/chan_sched.sv
// Channel scheduler top: START/BUSY/SHIFT sequencing of channels 0..NCH-1 per frame sync.
// Optional BUSY watchdog enabled by defining SCHED_TIMEOUT_EN.
module chan_sched
    import sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic         clk,
    input  logic         reset,
    chan_sched_if.master bus
);

    if (NCH > (1 << CW) || NCH < 1 || TMO < 1 || TMO > 255) begin : g_param_check
        $error("chan_sched: NCH must fit in CW bits and TMO must be 1..255");
    end

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] chan_q;
    logic [CW-1:0] chan_d;
    logic          last;
    logic          expired;
    logic          start_q, start_d;
    logic          shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          fdone_q, fdone_d;
    logic          overrun_q, overrun_d;

    assign last = (chan_q == CW'(NCH - 1));

`ifdef SCHED_TIMEOUT_EN
    logic timeout_q, timeout_d;

    sched_wdog #(.TMO(TMO)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == START),
        .run     (state == BUSY),
        .expired (expired)
    );

    // A watchdog expiry only counts as an error if done did not arrive in the same cycle.
    assign timeout_d = timeout_q | ((state == BUSY) && expired && !bus.done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timeout_q <= 1'b0;
        else       timeout_q <= timeout_d;
    end

    assign bus.timeout = timeout_q;
`else
    assign expired     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.fs && bus.en) state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY:    if (bus.done || expired) state_nxt = SHIFT;
            SHIFT:   state_nxt = last ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe comes straight off a flop.
    always_comb begin
        start_d   = (state_nxt == START);
        shift_d   = (state_nxt == SHIFT);
        busy_d    = (state_nxt != IDLE);
        fdone_d   = (state == SHIFT) && (state_nxt == IDLE);
        overrun_d = overrun_q | (bus.fs && (state != IDLE));
        chan_d    = chan_q;
        if (state == SHIFT) begin
            chan_d = last ? '0 : chan_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_q    <= '0;
            start_q   <= 1'b0;
            shift_q   <= 1'b0;
            busy_q    <= 1'b0;
            fdone_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            chan_q    <= chan_d;
            start_q   <= start_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            fdone_q   <= fdone_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.start      = start_q;
    assign bus.chan       = chan_q;
    assign bus.shift_en   = shift_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = fdone_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_chan_sched.sv
// Self-checking bench for chan_sched: frame vectors, back-to-back, mid-frame reset, watchdog.
module tb_chan_sched;
    import sched_pkg::*;

    localparam int NCH = NCH_DEF;
    localparam int CW  = CW_DEF;
    localparam int TMO = TMO_DEF;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b0;
    logic fs    = 1'b0;
    logic done  = 1'b0;

    chan_sched_if #(.CW(CW)) sb ();

    assign sb.en   = en;
    assign sb.fs   = fs;
    assign sb.done = done;

    chan_sched #(.NCH(NCH), .CW(CW), .TMO(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Delay-line model: output slot dl[0] must always carry the state of the channel in flight.
    int dl [NCH];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) dl[i] <= i;
        end else if (sb.shift_en) begin
            for (int i = 0; i < NCH - 1; i++) dl[i] <= dl[i+1];
            dl[NCH-1] <= dl[0];
        end
    end

    typedef struct {
        int en;
        int d;
        int hold;
        int ovr;
        int en_drop;
        int exp_ovr;
    } vec_t;

    vec_t vecs [5];

    int errors = 0;
    int checks = 0;
    int expq [$];
    int shift_cnt  = 0;
    int fd_cyc     = -1;
    int d_lat      = 1;
    int hold_done  = 0;
    int ovr_chan   = -1;
    int done_at    = -1;
    int skip_chan  = -1;
    int start_skip = -1;
    int shift_skip = -1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        int e;
        @(posedge clk);
        @(negedge clk);
        fs = 1'b0;
        if (sb.start) begin
            if (expq.size() == 0) begin
                chk("start_unexpected", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("start_chan", int'(sb.chan), e);
            end
            chk("dl_align", dl[0], int'(sb.chan));
            if (int'(sb.chan) == skip_chan) begin
                done_at    = -1;
                start_skip = cyc;
            end else begin
                done_at = cyc + d_lat;
            end
            if (int'(sb.chan) == ovr_chan) fs = 1'b1;
        end
        if (sb.shift_en) begin
            shift_cnt++;
            if (int'(sb.chan) == skip_chan) shift_skip = cyc;
        end
        if (sb.frame_done) fd_cyc = cyc;
        done = (hold_done != 0) || (cyc == done_at);
    endtask

    task automatic run_vec(input vec_t v);
        int fs_edge;
        int budget;
        en        = (v.en != 0);
        d_lat     = v.d;
        hold_done = v.hold;
        ovr_chan  = v.ovr;
        shift_cnt = 0;
        fd_cyc    = -1;
        fs        = 1'b1;
        fs_edge   = cyc + 1;
        if (v.en != 0) for (int i = 0; i < NCH; i++) expq.push_back(i);
        budget = NCH * (v.d + 2) + 20;
        for (int k = 0; k < budget && fd_cyc < 0; k++) begin
            tick();
            if (k == 0 && v.en_drop != 0) en = 1'b0;
        end
        hold_done = 0;
        ovr_chan  = -1;
        done_at   = -1;
        done      = 1'b0;
        chk("shift_count", shift_cnt, (v.en != 0) ? NCH : 0);
        chk("frame_done_cycle", fd_cyc, (v.en != 0) ? fs_edge + NCH * (v.d + 2) : -1);
        chk("chan_after", int'(sb.chan), 0);
        chk("busy_after", int'(sb.busy), 0);
        chk("overrun", int'(sb.overrun), v.exp_ovr);
        chk("scoreboard_empty", expq.size(), 0);
`ifndef SCHED_TIMEOUT_EN
        chk("timeout_tied", int'(sb.timeout), 0);
`else
        chk("timeout_clear", int'(sb.timeout), 0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, int'(sb.start), 0);
        chk({tag, "_chan"}, int'(sb.chan), 0);
        chk({tag, "_shift_en"}, int'(sb.shift_en), 0);
        chk({tag, "_busy"}, int'(sb.busy), 0);
        chk({tag, "_frame_done"}, int'(sb.frame_done), 0);
        chk({tag, "_overrun"}, int'(sb.overrun), 0);
        chk({tag, "_timeout"}, int'(sb.timeout), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int fs_edge;
        int guard;

        // en, done latency, done held, fs-at-channel, drop en mid-frame, expected overrun
        vecs[0] = '{en: 1, d: 2, hold: 0, ovr: -1, en_drop: 0, exp_ovr: 0};
        vecs[1] = '{en: 1, d: 1, hold: 1, ovr: -1, en_drop: 0, exp_ovr: 0};
        vecs[2] = '{en: 0, d: 1, hold: 0, ovr: -1, en_drop: 0, exp_ovr: 0};
        vecs[3] = '{en: 1, d: 3, hold: 0, ovr: 10, en_drop: 1, exp_ovr: 1};
        vecs[4] = '{en: 1, d: 1, hold: 0, ovr: -1, en_drop: 0, exp_ovr: 1};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("idle_busy", int'(sb.busy), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: fs raised in the frame_done cycle starts a new frame immediately.
        en = 1'b1; d_lat = 1; shift_cnt = 0; fd_cyc = -1;
        fs = 1'b1;
        for (int i = 0; i < NCH; i++) expq.push_back(i);
        for (int k = 0; k < NCH * 3 + 20 && fd_cyc < 0; k++) tick();
        chk("b2b_first_fd", int'(sb.frame_done), 1);
        fs = 1'b1;
        fs_edge = cyc + 1;
        shift_cnt = 0; fd_cyc = -1;
        for (int i = 0; i < NCH; i++) expq.push_back(i);
        tick();
        chk("b2b_start", int'(sb.start), 1);
        chk("b2b_chan", int'(sb.chan), 0);
        for (int k = 0; k < NCH * 3 + 20 && fd_cyc < 0; k++) tick();
        chk("b2b_second_fd", fd_cyc, fs_edge + NCH * 3);
        chk("b2b_shifts", shift_cnt, NCH);
        done_at = -1; done = 1'b0;

        // Reset asserted while channel 7 is waiting in BUSY.
        d_lat = 2; fs = 1'b1;
        for (int i = 0; i < NCH; i++) expq.push_back(i);
        guard = 0;
        while (!(sb.start && sb.chan == CW'(7)) && guard < 100) begin
            tick();
            guard++;
        end
        chk("reach_chan7", int'(sb.chan), 7);
        tick();
        chk("chan7_busy", int'(sb.busy), 1);
        #2 reset = 1'b1;
        #1 chk_all_zero("midreset");
        expq.delete();
        done_at = -1; done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("dl_after_reset", dl[0], 0);
        run_vec('{en: 1, d: 1, hold: 0, ovr: -1, en_drop: 0, exp_ovr: 0});

`ifdef SCHED_TIMEOUT_EN
        // Channel 3 never gets done; the watchdog must force its shift and keep the frame going.
        skip_chan = 3; d_lat = 1; en = 1'b1; shift_cnt = 0; fd_cyc = -1;
        fs = 1'b1;
        fs_edge = cyc + 1;
        for (int i = 0; i < NCH; i++) expq.push_back(i);
        for (int k = 0; k < NCH * 3 + TMO + 40 && fd_cyc < 0; k++) tick();
        chk("tmo_shift_cycle", shift_skip - start_skip, TMO + 2);
        chk("tmo_flag", int'(sb.timeout), 1);
        chk("tmo_shifts", shift_cnt, NCH);
        chk("tmo_fd_cycle", fd_cyc, fs_edge + NCH * 3 + TMO);
        chk("tmo_scoreboard", expq.size(), 0);
        skip_chan = -1;
        repeat (3) tick();
        chk("tmo_sticky", int'(sb.timeout), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
